// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pkg
//  Purpose  : 640x480@60 timing defaults, sync-bus type and 3-bit colour codes
//  Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

   localparam int CNT_W = 10;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int DEF_HS_FIRST = DEF_H_ACTIVE + DEF_H_FP;
   localparam int DEF_HS_LAST  = DEF_HS_FIRST + DEF_H_SYNC - 1;
   localparam int DEF_VS_FIRST = DEF_V_ACTIVE + DEF_V_FP;
   localparam int DEF_VS_LAST  = DEF_VS_FIRST + DEF_V_SYNC - 1;

   // Colour bits are {R,G,B}, matching the connector pin order.
   typedef logic [2:0] color_t;
   localparam color_t BLACK   = 3'b000;
   localparam color_t BLUE    = 3'b001;
   localparam color_t GREEN   = 3'b010;
   localparam color_t CYAN    = 3'b011;
   localparam color_t RED     = 3'b100;
   localparam color_t MAGENTA = 3'b101;
   localparam color_t YELLOW  = 3'b110;
   localparam color_t WHITE   = 3'b111;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic active;
   } sync_bus_t;

   function automatic logic sync_level(input logic pol, input logic asserted);
      return asserted ? pol : ~pol;
   endfunction

   function automatic logic in_window(input logic [CNT_W-1:0] v,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_delay.sv
`default_nettype none
// ============================================================================
//  Module   : sync_delay
//  Purpose  : WIDTH x DEPTH shift register, async active-low clear, DEPTH=0 bypass
//  Revision : 1.0 - initial release
// ============================================================================
module sync_delay #(
   parameter int               WIDTH   = 1,
   parameter int               DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   generate
      if (DEPTH == 0) begin : g_bypass
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst_n;
         assign q_o            = d_i;
      end else begin : g_shift
         logic [WIDTH-1:0] stage_q [DEPTH];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DEPTH; i++) begin
                  stage_q[i] <= RST_VAL;
               end
            end else begin
               stage_q[0] <= d_i;
               for (int i = 1; i < DEPTH; i++) begin
                  stage_q[i] <= stage_q[i-1];
               end
            end
         end

         assign q_o = stage_q[DEPTH-1];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_sync.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync
//  Purpose  : VGA raster counters, frame pulse, latency-matched sync and blanked RGB
//  Revision : 1.0 - initial release
// ============================================================================
module vga_sync
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE    = DEF_H_ACTIVE,
   parameter int   H_FP        = DEF_H_FP,
   parameter int   H_SYNC      = DEF_H_SYNC,
   parameter int   H_BP        = DEF_H_BP,
   parameter int   V_ACTIVE    = DEF_V_ACTIVE,
   parameter int   V_FP        = DEF_V_FP,
   parameter int   V_SYNC      = DEF_V_SYNC,
   parameter int   V_BP        = DEF_V_BP,
   parameter logic SYNC_POL    = 1'b0,
   parameter int   PIX_LATENCY = 1
) (
   input  logic             clk,
   input  logic             clr,
   output logic [CNT_W-1:0] x_px,
   output logic [CNT_W-1:0] y_px,
   input  logic [2:0]       color_px,
   output logic             frame_start,
   output logic             activevideo,
   output logic             hsync,
   output logic             vsync,
   output logic [2:0]       rgb
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   localparam sync_bus_t DLY_RST = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, active: 1'b0};

   generate
      if (H_TOTAL < 1 || H_TOTAL > (1 << CNT_W)) begin : g_bad_h_timing
         $error("vga_sync: horizontal timing total %0d does not fit the counter", H_TOTAL);
      end
      if (V_TOTAL < 1 || V_TOTAL > (1 << CNT_W)) begin : g_bad_v_timing
         $error("vga_sync: vertical timing total %0d does not fit the counter", V_TOTAL);
      end
      if (PIX_LATENCY < 0 || PIX_LATENCY > 4) begin : g_bad_latency
         $error("vga_sync: PIX_LATENCY %0d outside 0..4", PIX_LATENCY);
      end
   endgenerate

   logic [CNT_W-1:0] hc_q, hc_d;
   logic [CNT_W-1:0] vc_q, vc_d;
   logic             frame_start_q, frame_start_d;
   logic             hsync_q, vsync_q;
   color_t           rgb_q, rgb_d;
   logic             rst_n;
   sync_bus_t        raw_bus;
   sync_bus_t        dly_bus;

   assign rst_n = clr;

   always_comb begin
      hc_d          = hc_q + CNT_W'(1);
      vc_d          = vc_q;
      frame_start_d = 1'b0;
      if (hc_q == H_LAST) begin
         hc_d = '0;
         if (vc_q == V_LAST) begin
            vc_d          = '0;
            frame_start_d = 1'b1;
         end else begin
            vc_d = vc_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hc_q          <= '0;
         vc_q          <= '0;
         frame_start_q <= 1'b0;
      end else begin
         hc_q          <= hc_d;
         vc_q          <= vc_d;
         frame_start_q <= frame_start_d;
      end
   end

   always_comb begin
      raw_bus        = DLY_RST;
      raw_bus.hsync  = sync_level(SYNC_POL, in_window(hc_q, HS_FIRST, HS_LAST));
      raw_bus.vsync  = sync_level(SYNC_POL, in_window(vc_q, VS_FIRST, VS_LAST));
      raw_bus.active = (hc_q < H_VIS) && (vc_q < V_VIS);
   end

   // Aligns sync and visibility with the colour returned by the logo stage.
   sync_delay #(
      .WIDTH   ($bits(sync_bus_t)),
      .DEPTH   (PIX_LATENCY),
      .RST_VAL (DLY_RST)
   ) u_sync_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (raw_bus),
      .q_o   (dly_bus)
   );

   always_comb begin
      rgb_d = BLACK;
      if (dly_bus.active) begin
         rgb_d = color_px;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync_q <= ~SYNC_POL;
         vsync_q <= ~SYNC_POL;
         rgb_q   <= BLACK;
      end else begin
         hsync_q <= dly_bus.hsync;
         vsync_q <= dly_bus.vsync;
         rgb_q   <= rgb_d;
      end
   end

   assign x_px        = hc_q;
   assign y_px        = vc_q;
   assign activevideo = raw_bus.active;
   assign frame_start = frame_start_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign rgb         = rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_sync
//  Purpose  : self-checking bench for vga_sync against a raster arithmetic model
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vga_sync;

   typedef struct packed {
      int ha; int hf; int hs; int hb;
      int va; int vf; int vs; int vb;
      int pol; int lat;
   } cfg_t;

   logic       clk = 1'b0;
   logic       clr;
   logic [9:0] x_px  [3];
   logic [9:0] y_px  [3];
   logic [2:0] col   [3];
   logic [2:0] prev  [3];
   logic       fs    [3];
   logic       av    [3];
   logic       hs    [3];
   logic       vs    [3];
   logic [2:0] rgb   [3];

   int errors = 0;
   int checks = 0;
   int cur_m  = 0;
   int mode   = 0;
   bit lit_on = 0;
   int d0_hs_low = 0, d0_hs_first = -1, d0_lit = 0;
   int d1_fs_cnt = 0, d1_fs_first = -1, d1_hs_first = -1, d1_vs_hi = 0;
   int d2_hs_first = -1;

   always #5 clk = ~clk;

   vga_sync #(.H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
              .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
              .SYNC_POL(1'b0), .PIX_LATENCY(1)) u_dut0 (
      .clk(clk), .clr(clr), .x_px(x_px[0]), .y_px(y_px[0]), .color_px(col[0]),
      .frame_start(fs[0]), .activevideo(av[0]), .hsync(hs[0]), .vsync(vs[0]), .rgb(rgb[0]));

   vga_sync #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
              .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
              .SYNC_POL(1'b1), .PIX_LATENCY(0)) u_dut1 (
      .clk(clk), .clr(clr), .x_px(x_px[1]), .y_px(y_px[1]), .color_px(col[1]),
      .frame_start(fs[1]), .activevideo(av[1]), .hsync(hs[1]), .vsync(vs[1]), .rgb(rgb[1]));

   vga_sync #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
              .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
              .SYNC_POL(1'b0), .PIX_LATENCY(3)) u_dut2 (
      .clk(clk), .clr(clr), .x_px(x_px[2]), .y_px(y_px[2]), .color_px(col[2]),
      .frame_start(fs[2]), .activevideo(av[2]), .hsync(hs[2]), .vsync(vs[2]), .rgb(rgb[2]));

   function automatic cfg_t get_cfg(input int d);
      cfg_t c;
      if (d == 0) c = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, pol:0, lat:1};
      else if (d == 1) c = '{ha:8, hf:2, hs:3, hb:3, va:6, vf:1, vs:2, vb:2, pol:1, lat:0};
      else c = '{ha:8, hf:2, hs:3, hb:3, va:6, vf:1, vs:2, vb:2, pol:0, lat:3};
      return c;
   endfunction

   function automatic int htot(input cfg_t c); return c.ha + c.hf + c.hs + c.hb; endfunction
   function automatic int vtot(input cfg_t c); return c.va + c.vf + c.vs + c.vb; endfunction
   function automatic int col_of(input cfg_t c, input int n); return n % htot(c); endfunction
   function automatic int line_of(input cfg_t c, input int n); return (n / htot(c)) % vtot(c); endfunction

   function automatic bit visible(input cfg_t c, input int n);
      return (col_of(c, n) < c.ha) && (line_of(c, n) < c.va);
   endfunction

   function automatic int hs_level(input cfg_t c, input int n);
      int h = col_of(c, n);
      bit on = (h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs);
      return on ? c.pol : 1 - c.pol;
   endfunction

   function automatic int vs_level(input cfg_t c, input int n);
      int v = line_of(c, n);
      bit on = (v >= c.va + c.vf) && (v < c.va + c.vf + c.vs);
      return on ? c.pol : 1 - c.pol;
   endfunction

   task automatic cmp(input string nm, input int d, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, d, cur_m, got, exp);
      end
   endtask

   // Pins at cycle m reflect the counters of cycle m-1-lat and the colour driven in cycle m-1.
   task automatic check_dut(input int d, input int m);
      cfg_t c = get_cfg(d);
      int   s = m - 1 - c.lat;
      int   e_hs, e_vs, e_rgb;
      cmp("x_px", d, int'(x_px[d]), col_of(c, m));
      cmp("y_px", d, int'(y_px[d]), line_of(c, m));
      cmp("activevideo", d, int'(av[d]), int'(visible(c, m)));
      cmp("frame_start", d, int'(fs[d]), int'(m > 0 && (m % (htot(c) * vtot(c))) == 0));
      if (s < 0) begin
         e_hs  = 1 - c.pol;
         e_vs  = 1 - c.pol;
         e_rgb = 0;
      end else begin
         e_hs  = hs_level(c, s);
         e_vs  = vs_level(c, s);
         e_rgb = visible(c, s) ? int'(prev[d]) : 0;
      end
      cmp("hsync", d, int'(hs[d]), e_hs);
      cmp("vsync", d, int'(vs[d]), e_vs);
      cmp("rgb", d, int'(rgb[d]), e_rgb);
   endtask

   task automatic check_reset(input string tag);
      for (int d = 0; d < 3; d++) begin
         cfg_t c = get_cfg(d);
         cmp({tag, "_x"}, d, int'(x_px[d]), 0);
         cmp({tag, "_y"}, d, int'(y_px[d]), 0);
         cmp({tag, "_hsync"}, d, int'(hs[d]), 1 - c.pol);
         cmp({tag, "_vsync"}, d, int'(vs[d]), 1 - c.pol);
         cmp({tag, "_rgb"}, d, int'(rgb[d]), 0);
         cmp({tag, "_frame"}, d, int'(fs[d]), 0);
         cmp({tag, "_active"}, d, int'(av[d]), 1);
      end
   endtask

   task automatic drive(input int m);
      for (int d = 0; d < 3; d++) begin
         cfg_t c = get_cfg(d);
         case (mode)
            1:       col[d] = 3'b111;
            2:       col[d] = (m == 0) ? 3'd0 : 3'(col_of(c, m - 1) & 7);
            default: col[d] = 3'($urandom_range(0, 7));
         endcase
         prev[d] = col[d];
      end
   endtask

   task automatic tally(input int m);
      if (!lit_on) return;
      if (m >= 1 && m <= 800) begin
         if (hs[0] == 1'b0) begin
            d0_hs_low++;
            if (d0_hs_first < 0) d0_hs_first = m;
         end
         if (rgb[0] == 3'b111) d0_lit++;
      end
      if (m >= 1 && m <= 600 && fs[1]) begin
         d1_fs_cnt++;
         if (d1_fs_first < 0) d1_fs_first = m;
      end
      if (m >= 1 && m <= 176 && vs[1]) d1_vs_hi++;
      if (d1_hs_first < 0 && hs[1]) d1_hs_first = m;
      if (d2_hs_first < 0 && !hs[2]) d2_hs_first = m;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         cur_m++;
         for (int d = 0; d < 3; d++) check_dut(d, cur_m);
         tally(cur_m);
         drive(cur_m);
      end
   endtask

   initial begin
      clr = 1'b0;
      for (int d = 0; d < 3; d++) begin
         col[d]  = 3'd0;
         prev[d] = 3'd0;
      end
      #23;
      check_reset("por");
      cur_m = 0;
      mode  = 0;
      drive(0);
      #5 clr = 1'b1;
      run(666);

      // Mid-line, inside hsync on dut0 and inside hsync+vsync on the small rasters.
      #3 clr = 1'b0;
      #1 check_reset("async");
      repeat (3) @(posedge clk);
      #1 check_reset("hold");

      mode   = 1;
      cur_m  = 0;
      drive(0);
      lit_on = 1;
      #3 clr = 1'b1;
      run(1600);
      lit_on = 0;
      mode   = 2;
      run(2400);
      mode   = 0;
      run(2400);

      cmp("d0_hsync_low_clocks", 0, d0_hs_low, 96);
      cmp("d0_hsync_first_low", 0, d0_hs_first, 658);
      cmp("d0_lit_clocks_line0", 0, d0_lit, 640);
      cmp("d1_frame_pulses", 1, d1_fs_cnt, 3);
      cmp("d1_first_frame_pulse", 1, d1_fs_first, 176);
      cmp("d1_vsync_high_clocks", 1, d1_vs_hi, 32);
      cmp("d1_hsync_first_high", 1, d1_hs_first, 11);
      cmp("d2_hsync_first_low", 2, d2_hs_first, 14);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_sync.md
Name: vga_sync

Overview:
- Upstream timing stage for the VGA screen examples.
- Generates the 640x480@60Hz raster: pixel coordinates x_px/y_px go to the logo stage, and a per-frame pulse drives its motion update.
- Takes the logo's color_px back in, aligns hsync/vsync/blanking to that colour's pipeline latency, and drives the blanked RGB and sync pins.
- clk is the pixel clock, nominally 25 MHz, from the board PLL.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
- PIX_LATENCY, 1, clk cycles from x_px/y_px to the matching color_px; range 0..4

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- clr  in  1  reset, asynchronous, active-low (0 = reset)
- x_px  out  10  current column counter hc
- y_px  out  10  current line counter vc
- color_px  in  3  colour from logo stage, PIX_LATENCY cycles behind x_px/y_px
- frame_start  out  1  one-cycle pulse when (hc,vc) = (0,0)
- activevideo  out  1  hc<H_ACTIVE and vc<V_ACTIVE, undelayed, for downstream users of x_px/y_px
- hsync  out  1  horizontal sync to connector, delayed PIX_LATENCY
- vsync  out  1  vertical sync to connector, delayed PIX_LATENCY
- rgb  out  3  colour to connector: {R,G,B}, blanked

Behaviour:
- Derived totals: H_TOTAL = 800, V_TOTAL = 525; one frame = 420000 clocks.
- hc counts 0..H_TOTAL-1 every clock and wraps to 0.
- vc increments only on the cycle hc wraps, counts 0..V_TOTAL-1 and wraps to 0.
- x_px = hc and y_px = vc, straight from the counter registers, with no extra delay. Values stay valid outside the active area; consumers qualify them with activevideo.
- Raw hsync is asserted when 656 <= hc <= 751 (H_ACTIVE+H_FP .. +H_SYNC-1).
- Raw vsync is asserted when 490 <= vc <= 491.
- Asserted level = SYNC_POL, deasserted level = !SYNC_POL.
- Delay line: raw {hsync, vsync, activevideo} passes through PIX_LATENCY registers to give hsync, vsync and vis_d. PIX_LATENCY=0 is a combinational bypass.
- rgb is registered: rgb <= vis_d ? color_px : 3'b000, which adds one output cycle.
  - hsync/vsync are re-registered alongside rgb so all three pins change on the same edge.
  - Total pin latency = PIX_LATENCY+1 clocks after the counters.
- frame_start is registered: it goes high on the cycle the counters are (0,0) after a wrap from (799,524), and lasts exactly one clock.
  - No pulse appears for the partial first frame after reset.
  - The first pulse comes 420000 clocks after reset release.
- Reset (clr=0), asynchronous, effective immediately, including mid-line or mid-sync:
  - hc = vc = 0; delay-line stages cleared to the deasserted/blank state.
  - hsync = vsync = !SYNC_POL; rgb = 0; frame_start = 0.
  - activevideo reflects counters (0,0), i.e. 1.
- Simultaneous hc and vc wrap at (799,524): both go to 0 on the same edge.
- Blanking takes priority over color_px: any non-zero colour during porches or sync gives rgb = 0.
- Parameter legality: the sum of each set of timing fields must fit in 10 bits. This is checked at elaboration; a violation is an elaboration error.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480@60 default timing constants;
  - derived H_TOTAL/V_TOTAL and the sync start/end positions;
  - the 3-bit colour encoding constants (BLACK, RED, ... WHITE) shared with the graphics stage.
- One sub-module, sync_delay: a parameterised WIDTH x DEPTH shift register with async active-low clear to a given reset value, and DEPTH=0 bypass. It is instantiated once for {hsync, vsync, activevideo}.

Test Plan:
- Reset release, then run 420000 clocks.
  -> x_px steps 0..799; y_px increments when x_px wraps and wraps from 524 to 0.
  -> frame_start high only at clock 420000.
- PIX_LATENCY=1, sample one line.
  -> hsync low for exactly 96 clocks, first low pin at hc=658 (656+2), high otherwise.
  -> vsync low exactly on lines 490-491 (2 x 800 clocks).
- color_px held at 3'b111 constantly.
  -> rgb = 3'b111 only on pin cycles aligned to hc 0..639 and vc 0..479, otherwise 0; 640 lit clocks per visible line, 0 on lines 480-524.
- Pattern color_px = hc[2:0] delayed by 1.
  -> rgb equals x_px[2:0] from two clocks earlier for every visible pixel, with no off-by-one at hc=0 or hc=639.
- Assert clr at hc=700, vc=491 (inside hsync and vsync).
  -> same timestep: hsync = vsync = 1, rgb = 0, x_px = y_px = 0.
  -> after release, counting restarts from 0 with no frame_start until the next wrap.
- SYNC_POL=1 and PIX_LATENCY=0.
  -> hsync high for hc 656..751, pin latency 1 clock; reset value hsync = vsync = 0.
